// File: rtl/ram_access_controller_pkg.sv
// ---------------------------------------------------------------------------
// ram_access_controller_pkg
// Shared definitions for the RAMblock bus master: the RAM address/data widths
// used throughout the processor and the controller state encoding.
// Contents:
//   adlines    RAM address width
//   datalines  RAM data width
//   state_t    controller states (IDLE=0 .. DONE=5)
//   max_int    elaboration-time helper for sizing the pulse counter
// ---------------------------------------------------------------------------
package ram_access_controller_pkg;

  localparam int adlines   = 8;
  localparam int datalines = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WSTROBE = 3'd2,
    RSTROBE = 3'd3,
    HOLD    = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Larger of two integers; used so one counter covers both strobe lengths.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ram_access_controller.sv
// ---------------------------------------------------------------------------
// ram_access_controller
// Synchronous bus master for the asynchronous, level-strobed RAMblock.
// Takes one CPU request at a time, holds the address/data stable around the
// read or write strobe (one setup cycle before, one hold cycle after), and
// registers the read data. Every output comes straight from a flop.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   req          in   CPU request, only looked at while idle
//   we           in   1 = write, 0 = read (sampled with req)
//   addr         in   request address (sampled with req)
//   wdata        in   write data (sampled with req)
//   busy         out  high from the cycle after acceptance through DONE
//   ack          out  one-cycle completion pulse
//   rdata        out  read data, valid with ack and held until the next read
//   ram_address  out  RAMblock address
//   ram_datain   out  RAMblock write data
//   ram_read     out  RAMblock read strobe
//   ram_write    out  RAMblock write strobe
//   ram_dataout  in   RAMblock read data
// ---------------------------------------------------------------------------
module ram_access_controller
  import ram_access_controller_pkg::*;
#(
  parameter int WR_PULSE = 4,
  parameter int RD_WAIT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [adlines-1:0]   addr,
  input  logic [datalines-1:0] wdata,
  output logic                 busy,
  output logic                 ack,
  output logic [datalines-1:0] rdata,
  output logic [adlines-1:0]   ram_address,
  output logic [datalines-1:0] ram_datain,
  output logic                 ram_read,
  output logic                 ram_write,
  input  logic [datalines-1:0] ram_dataout
);

  // One extra bit over what the longest pulse needs, so PULSE-1 always fits.
  localparam int cw = $clog2(max_int(WR_PULSE, RD_WAIT)) + 1;

  // A zero-length strobe would leave the RAM untouched; refuse to build it.
  if (WR_PULSE < 1 || RD_WAIT < 1) begin : g_param_check
    $error("ram_access_controller: WR_PULSE and RD_WAIT must both be >= 1");
  end

  state_t          state;
  logic [cw-1:0]   count;
  logic            we_q;

  // Controller FSM with all datapath registers kept alongside it.
  // The address and write data are captured on acceptance and never touched
  // again until the next acceptance, so they are stable for the whole setup,
  // strobe and hold window. The strobes only rise when leaving SETUP and only
  // fall when leaving the strobe state, i.e. never on an edge that also moves
  // the address or data. The counter is loaded with PULSE-1 in SETUP and the
  // strobe state ends on the cycle it reads zero, giving exactly PULSE strobe
  // cycles. A reset mid-strobe drops the strobe immediately and loses the
  // transaction without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      ack         <= 1'b0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      rdata       <= '0;
      ram_address <= '0;
      ram_datain  <= '0;
      count       <= '0;
      we_q        <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            ram_address <= addr;
            if (we) begin
              ram_datain <= wdata;
            end
            we_q  <= we;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end

        SETUP: begin
          if (we_q) begin
            count     <= cw'(WR_PULSE - 1);
            ram_write <= 1'b1;
            state     <= WSTROBE;
          end else begin
            count     <= cw'(RD_WAIT - 1);
            ram_read  <= 1'b1;
            state     <= RSTROBE;
          end
        end

        WSTROBE: begin
          if (count == '0) begin
            ram_write <= 1'b0;
            state     <= HOLD;
          end else begin
            count <= count - 1'b1;
          end
        end

        RSTROBE: begin
          if (count == '0) begin
            // Last strobe cycle: RAM output has had RD_WAIT cycles to settle.
            rdata    <= ram_dataout;
            ram_read <= 1'b0;
            state    <= HOLD;
          end else begin
            count <= count - 1'b1;
          end
        end

        HOLD: begin
          ack   <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_controller.sv
// ---------------------------------------------------------------------------
// tb_ram_access_controller
// Self-checking bench: drives ram_access_controller (WR_PULSE=4, RD_WAIT=2)
// against a behavioural RAMblock and a reference memory/rdata model, plus a
// free-running monitor for strobe exclusivity and address/data margins.
// ---------------------------------------------------------------------------
module tb_ram_access_controller;
  import ram_access_controller_pkg::*;

  localparam int WRP  = 4;
  localparam int RDW  = 2;
  localparam int MAXC = 40;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req;
  logic                 we;
  logic [adlines-1:0]   addr;
  logic [datalines-1:0] wdata;
  logic                 busy;
  logic                 ack;
  logic [datalines-1:0] rdata;
  logic [adlines-1:0]   ram_address;
  logic [datalines-1:0] ram_datain;
  logic                 ram_read;
  logic                 ram_write;
  logic [datalines-1:0] ram_dataout;

  int checks = 0;
  int errors = 0;

  ram_access_controller #(.WR_PULSE(WRP), .RD_WAIT(RDW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .ack         (ack),
    .rdata       (rdata),
    .ram_address (ram_address),
    .ram_datain  (ram_datain),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_dataout (ram_dataout)
  );

  always #5 clk = ~clk;

  // Power-on contents of the RAM cells.
  function automatic logic [15:0] initVal(input int i);
    return 16'(16'h1000 + i * 7);
  endfunction

  // Behavioural RAMblock: level-strobed write, data visible while read is high.
  logic [15:0] mem [256];
  bit          memLoaded = 1'b0;
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= initVal(i);
      memLoaded <= 1'b1;
    end else if (ram_write) begin
      mem[ram_address] <= ram_datain;
    end
  end
  assign ram_dataout = ram_read ? mem[ram_address] : '0;

  // Reference model: what each cell should hold and what rdata should show.
  logic [15:0] refMem [256];
  logic [15:0] refRdata;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h required=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: strobes mutually exclusive; address/data unchanged in any cycle
  // whose strobe, or the previous cycle's strobe, is high. Skipped around reset.
  logic [7:0]  prevAddr   = '0;
  logic [15:0] prevDin    = '0;
  logic        prevStrobe = 1'b0;
  logic        resetPrev  = 1'b1;
  always @(negedge clk) begin
    if (!reset && !resetPrev) begin
      if (ram_read || ram_write)
        checkOutput("strobeExcl", 32'(ram_read & ram_write), 32'd0);
      if (ram_read || ram_write || prevStrobe)
        checkOutput("strobeMargin",
                    32'((ram_address != prevAddr) || (ram_datain != prevDin)), 32'd0);
    end
    prevAddr   = ram_address;
    prevDin    = ram_datain;
    prevStrobe = ram_read | ram_write;
    resetPrev  = reset;
  end

  // One full transaction, started at a negedge with the DUT idle. Returns at
  // the negedge of the idle cycle that follows DONE. With keepReq, req stays
  // high and the other inputs are scrambled while busy to show they are ignored.
  task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [15:0] d,
                               input bit keepReq);
    int          n;
    int          wrCycles;
    int          rdCycles;
    int          expLat;
    bit          gotAck;
    logic [15:0] expRd;
    expLat = w ? WRP + 3 : RDW + 3;
    if (w) begin
      refMem[a] = d;
      expRd     = refRdata;
    end else begin
      expRd    = refMem[a];
      refRdata = refMem[a];
    end
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    n = 0; wrCycles = 0; rdCycles = 0; gotAck = 1'b0;
    while (!gotAck && n < MAXC) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checkOutput("busyStart", 32'(busy), 32'd1);
        checkOutput("addrLatch", 32'(ram_address), 32'(a));
        if (w) checkOutput("dataLatch", 32'(ram_datain), 32'(d));
        if (!keepReq) req = 1'b0;
      end
      if (ram_write) wrCycles++;
      if (ram_read)  rdCycles++;
      if (ack) gotAck = 1'b1;
      else if (keepReq) begin
        we    = 1'($urandom);
        addr  = 8'($urandom);
        wdata = 16'($urandom);
      end
    end
    if (!gotAck) begin
      checkOutput("ackTimeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("latency",   32'(n), 32'(expLat));
    checkOutput("busyAtAck", 32'(busy), 32'd1);
    checkOutput("rdata",     32'(rdata), 32'(expRd));
    checkOutput("wrPulse",   32'(wrCycles), w ? 32'(WRP) : 32'd0);
    checkOutput("rdPulse",   32'(rdCycles), w ? 32'd0 : 32'(RDW));
    @(negedge clk);
    checkOutput("idleGap", 32'(busy), 32'd0);
    checkOutput("ackOnce", 32'(ack), 32'd0);
  endtask

  logic [7:0]  lastA;
  logic [15:0] rd;

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    refRdata = '0;
    for (int i = 0; i < 256; i++) refMem[i] = initVal(i);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    checkOutput("rstBusy",  32'(busy), 32'd0);
    checkOutput("rstAck",   32'(ack), 32'd0);
    checkOutput("rstRead",  32'(ram_read), 32'd0);
    checkOutput("rstWrite", 32'(ram_write), 32'd0);
    checkOutput("rstRdata", 32'(rdata), 32'd0);
    checkOutput("rstAddr",  32'(ram_address), 32'd0);
    checkOutput("rstDin",   32'(ram_datain), 32'd0);

    // Directed writes then reads, including the untouched cell 0.
    applyStimulus(1'b1, 8'd11, 16'd10,   1'b0);
    applyStimulus(1'b1, 8'd19, 16'd17,   1'b0);
    applyStimulus(1'b1, 8'd65, 16'd1003, 1'b0);
    applyStimulus(1'b0, 8'd11, 16'h0,    1'b0);
    checkOutput("read11", 32'(rdata), 32'd10);
    applyStimulus(1'b0, 8'd19, 16'h0,    1'b0);
    applyStimulus(1'b0, 8'd65, 16'h0,    1'b0);
    checkOutput("read65", 32'(rdata), 32'd1003);
    applyStimulus(1'b0, 8'd0,  16'h0,    1'b0);
    checkOutput("read0Init", 32'(rdata), 32'h1000);

    // req held high: alternating write / read-back, one idle cycle apart.
    lastA = 8'd100;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        lastA = 8'($urandom_range(100, 199));
        applyStimulus(1'b1, lastA, 16'($urandom), 1'b1);
      end else begin
        applyStimulus(1'b0, lastA, 16'($urandom), 1'b1);
      end
    end
    req = 1'b0;

    // Random single transactions away from the directed cells.
    for (int k = 0; k < 12; k++)
      applyStimulus(1'($urandom), 8'($urandom_range(100, 250)), 16'($urandom), 1'b0);

    // Reset on the second WSTROBE cycle of write 55@33.
    req = 1'b1; we = 1'b1; addr = 8'd33; wdata = 16'd55;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5StrobeOn", 32'(ram_write), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("t5WriteDrop", 32'(ram_write), 32'd0);
    checkOutput("t5Busy",      32'(busy), 32'd0);
    checkOutput("t5Ack",       32'(ack), 32'd0);
    refRdata = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checkOutput("t5NoAck", 32'(ack), 32'd0);
    applyStimulus(1'b0, 8'd11, 16'h0, 1'b0);
    checkOutput("t5Read11", 32'(rdata), 32'd10);

    // Reset on the first RSTROBE cycle of a read.
    req = 1'b1; we = 1'b0; addr = 8'd19;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    checkOutput("t6StrobeOn", 32'(ram_read), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("t6ReadDrop", 32'(ram_read), 32'd0);
    checkOutput("t6Rdata",    32'(rdata), 32'd0);
    refRdata = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 8'd19, 16'h0, 1'b0);
    rd = rdata;
    checkOutput("t6Read19", 32'(rd), 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
